adc_axis_downsizer: RTL and testbench
=====================================

# adc_axis_downsizer

Single-clock AXI-stream width down-converter between the ADC capture controller's 128-bit CPU-bound stream and the PL-to-PS crossing stage. It buffers up to two 128-bit words and emits them as OUT_WIDTH-bit beats, least-significant lane first. It marks frame boundaries with `m_axis_tlast` and supports a synchronous flush driven from the GPIO buffer-flush control line.

## Interface
- `OUT_WIDTH`, default 32: output beat width. Legal values are 32 and 64. `RATIO = 128/OUT_WIDTH`.
- `FRAME_WORDS`, default 256: number of 128-bit input words per frame. Legal range is 1 to 65535.
- `pl_clk` input, 1 bit: the single clock. All logic is on its rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `flush` input, 1 bit: synchronous buffer flush, active-high, tied to `gpio_ctrl[adc_buffer_flush]`.
- `s_axis_tdata` input, 128 bits: word from the ADC controller.
- `s_axis_tvalid` input, 1 bit.
- `s_axis_tready` output, 1 bit: registered.
- `m_axis_tdata` output, OUT_WIDTH bits: beat toward the PL-to-PS stage.
- `m_axis_tvalid` output, 1 bit.
- `m_axis_tready` input, 1 bit.
- `m_axis_tlast` output, 1 bit: high on the final beat of each frame.
- `frames_done` output, 16 bits: count of completed frames. Wraps at 2^16.

## Operation
- Storage is a 2-entry FIFO of 128-bit words with head/tail pointers and a 2-bit `count` (0 to 2).
- The beat index `beat` runs from 0 to RATIO-1. `m_axis_tdata = head[beat*OUT_WIDTH +: OUT_WIDTH]`.
- `m_axis_tvalid = (count != 0)`.
- Input handshake:
  - A word is accepted when `s_axis_tvalid && s_axis_tready`.
  - The `s_axis_tready` register is loaded each cycle with `(next_count < 2) && !flush`.
  - Ready is never combinationally dependent on `m_axis_tready`.
- Output handshake:
  - A beat is consumed when `m_axis_tvalid && m_axis_tready`. `beat` then increments.
  - At `beat == RATIO-1`, `beat` returns to 0, the head word pops, and `count` decrements.
- Simultaneous pop and push in the same cycle leave `count` unchanged. Both pointers advance.
- Frame counter `word_idx` runs from 0 to FRAME_WORDS-1 and increments on each head pop.
  - `m_axis_tlast = m_axis_tvalid && (beat == RATIO-1) && (word_idx == FRAME_WORDS-1)`.
  - When a tlast beat is consumed, `word_idx` wraps to 0 and `frames_done` increments.
- AXI rule: once `m_axis_tvalid` is high, `m_axis_tdata` and `m_axis_tlast` stay stable until the beat is consumed.
- Flush:
  - While `flush` is high, at each edge: `count`, `beat`, `word_idx` and both pointers go to 0, and `s_axis_tready` goes to 0.
  - Flush does not clear `frames_done`.
  - Any input offered during flush is not accepted. An in-progress output beat is discarded. Flush overrides a simultaneous push or pop.
- Reset (`rst` low, any time including mid-frame):
  - All state clears immediately: `count`, `beat`, `word_idx`, `frames_done` = 0.
  - Outputs read `s_axis_tready=0`, `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`. FIFO data registers reset to 0.

## Timing
- `s_axis_tready` rises at the first `pl_clk` edge after `rst` deasserts.
- Latency: a word accepted at edge k into an empty buffer shows beat 0 with `m_axis_tvalid=1` in the cycle after edge k.
- Throughput: with `m_axis_tready` held high, one beat per cycle. The output side never bubbles between words while `count==2`.
- Input sustains 1 word per RATIO cycles.
- Stall behaviour:
  - With `m_axis_tready=0`, two words are accepted and then `s_axis_tready` falls.
  - It rises again in the cycle after the first head pop.
- After flush deasserts, `s_axis_tready` returns to 1 at the next edge.

## Test plan
- **Reset and single word.** Release reset, push 0x0F0E0D0C_0B0A0908_07060504_03020100 with `m_axis_tready=1`, OUT_WIDTH=32.
  - Beats are 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on 4 consecutive cycles, starting 1 cycle after acceptance.
  - `m_axis_tvalid` drops afterwards.
- **Back-pressure.** Hold `m_axis_tready=0` and offer 3 words.
  - Exactly 2 are accepted and `s_axis_tready=0`.
  - Raising ready drains 8 beats in order, and the 3rd word is accepted after the first pop.
- **Random stalls.** With FRAME_WORDS=4, stream 12 counting words under random `m_axis_tready`.
  - No beat is lost or duplicated, and data stays stable while stalled.
  - `m_axis_tlast` is high on beats 16, 32 and 48, and `frames_done=3`.
- **Flush mid-word.** Assert `flush` for 1 cycle while `beat=2` and `count=2`.
  - Next cycle: `m_axis_tvalid=0`, `count=0`, `s_axis_tready=0`, `frames_done` unchanged.
  - The next pushed word starts at beat 0 with `word_idx=0`.
- **Async reset mid-frame.** Drop `rst` between clock edges during output.
  - All outputs go to 0 without a clock edge. After release, normal operation resumes from an empty buffer.
- **OUT_WIDTH=64.** Push one word with FRAME_WORDS=1.
  - 2 beats come out, low half first, with `m_axis_tlast` on beat 2 and `frames_done=1`.

Source files
------------

// File: rtl/adc_axis_downsizer.sv
// 128-bit to OUT_WIDTH-bit AXI-stream down-converter with a two-word buffer,
// frame tlast generation, frame counter and synchronous flush.
module adc_axis_downsizer #(
  parameter int OUT_WIDTH   = 32,
  parameter int FRAME_WORDS = 256
) (
  input  logic                 pl_clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [127:0]         s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [15:0]          frames_done
);

  localparam int RATIO = 128 / OUT_WIDTH;
  localparam int BW    = (RATIO > 2) ? 2 : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
  localparam logic [15:0]   LAST_WORD = 16'(FRAME_WORDS - 1);

  logic [127:0]  mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    next_count;
  logic [BW-1:0] beat;
  logic [15:0]   word_idx;
  logic          s_ready;
  logic          push;
  logic          beat_done;
  logic          pop;
  logic [6:0]    lane_lsb;

  assign s_axis_tready = s_ready;
  assign push          = s_axis_tvalid && s_ready;
  assign m_axis_tvalid = (count != 2'd0);
  assign beat_done     = m_axis_tvalid && m_axis_tready;
  assign pop           = beat_done && (beat == LAST_BEAT);
  assign m_axis_tlast  = m_axis_tvalid && (beat == LAST_BEAT) && (word_idx == LAST_WORD);

  // Lane select, least-significant lane first.
  assign lane_lsb     = 7'(beat) * 7'(OUT_WIDTH);
  assign m_axis_tdata = mem[rd_ptr][lane_lsb +: OUT_WIDTH];

  always_comb begin
    next_count = count;
    if (push && !pop) begin
      next_count = count + 2'd1;
    end else if (pop && !push) begin
      next_count = count - 2'd1;
    end
  end

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      beat        <= '0;
      word_idx    <= 16'd0;
      frames_done <= 16'd0;
      s_ready     <= 1'b0;
    end else if (flush) begin
      // Flush drops buffered words but keeps the completed-frame count.
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      beat     <= '0;
      word_idx <= 16'd0;
      s_ready  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_axis_tdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (beat_done) begin
        if (beat == LAST_BEAT) begin
          beat   <= '0;
          rd_ptr <= ~rd_ptr;
          if (word_idx == LAST_WORD) begin
            word_idx    <= 16'd0;
            frames_done <= frames_done + 16'd1;
          end else begin
            word_idx <= word_idx + 16'd1;
          end
        end else begin
          beat <= beat + BW'(1);
        end
      end
      count   <= next_count;
      s_ready <= (next_count < 2'd2);
    end
  end

endmodule

// File: tb/tb_adc_axis_downsizer.sv
// Bench for adc_axis_downsizer: beat-queue reference model with per-cycle compare,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_adc_axis_downsizer;

  logic         pl_clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;

  logic [127:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic [15:0]  frames;

  logic [127:0] s_data64 = '0;
  logic         s_valid64 = 1'b0;
  logic         s_ready64;
  logic [63:0]  m_data64;
  logic         m_valid64;
  logic         m_ready64 = 1'b0;
  logic         m_last64;
  logic [15:0]  frames64;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 pl_clk = ~pl_clk;

  adc_axis_downsizer #(.OUT_WIDTH(32), .FRAME_WORDS(4)) dut (
    .pl_clk(pl_clk), .rst(rst), .flush(flush),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last), .frames_done(frames)
  );

  adc_axis_downsizer #(.OUT_WIDTH(64), .FRAME_WORDS(1)) dut64 (
    .pl_clk(pl_clk), .rst(rst), .flush(flush),
    .s_axis_tdata(s_data64), .s_axis_tvalid(s_valid64), .s_axis_tready(s_ready64),
    .m_axis_tdata(m_data64), .m_axis_tvalid(m_valid64), .m_axis_tready(m_ready64),
    .m_axis_tlast(m_last64), .frames_done(frames64)
  );

  task chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the 32-bit instance: each accepted word becomes four
  // queued beats {last, data}; the frame position decides which beat is last.
  logic [32:0] exp_q [$];
  int m_pos = 0;
  int m_frames = 0;
  bit m_armed = 1'b0;
  int words_held;

  always @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_pos = 0;
      m_frames = 0;
      m_armed = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_pos = 0;
      m_armed = 1'b0;
    end else begin
      if (m_valid && m_ready && exp_q.size() != 0) begin
        if (exp_q[0][32]) m_frames++;
        void'(exp_q.pop_front());
      end
      if (s_valid && s_ready) begin
        for (int l = 0; l < 4; l++)
          exp_q.push_back({(l == 3 && m_pos == 3), s_data[32*l +: 32]});
        m_pos = (m_pos + 1) % 4;
      end
      m_armed = 1'b1;
    end
  end

  always @(negedge pl_clk) begin
    if (chk_en) begin
      words_held = (exp_q.size() + 3) / 4;
      chk("model tvalid", m_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("model tdata", m_data, exp_q[0][31:0]);
        chk("model tlast", m_last, exp_q[0][32]);
      end
      chk("model tready", s_ready, m_armed && words_held < 2);
      chk("model frames_done", frames, 16'(m_frames));
    end
  end

  task automatic push_word(input logic [127:0] d, output int n);
    bit acc;
    acc = 1'b0;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    while (!acc && n < 200) begin
      acc = s_ready;
      @(posedge pl_clk); #1;
      n++;
    end
    s_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push timeout: got no accept want accept within 200 cycles");
    end
  endtask

  function automatic logic [127:0] cnt_word(input int base);
    logic [127:0] w;
    for (int l = 0; l < 4; l++) w[32*l +: 32] = 32'(base + l);
    return w;
  endfunction

  localparam logic [127:0] W0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  int n;
  int seen;
  int lasts;
  int cyc;
  bit acc64;
  int n64;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish before 400us");
    $fatal(1);
  end

  initial begin
    // Reset and single word
    rst = 1'b0;
    repeat (3) @(posedge pl_clk);
    #1;
    chk_en = 1'b1;
    chk("reset tready", s_ready, 0);
    chk("reset tvalid", m_valid, 0);
    chk("reset tdata", m_data, 0);
    chk("reset frames_done", frames, 0);
    rst = 1'b1;
    #1;
    chk("tready before first edge", s_ready, 0);
    @(posedge pl_clk); #1;
    chk("tready after release", s_ready, 1);
    m_ready = 1'b1;
    push_word(W0, n);
    chk("single accept cycles", n, 1);
    chk("single beat0", m_data, 32'h03020100);
    @(posedge pl_clk); #1;
    chk("single beat1", m_data, 32'h07060504);
    @(posedge pl_clk); #1;
    chk("single beat2", m_data, 32'h0B0A0908);
    @(posedge pl_clk); #1;
    chk("single beat3", m_data, 32'h0F0E0D0C);
    @(posedge pl_clk); #1;
    chk("single tvalid drop", m_valid, 0);

    // Back-pressure
    m_ready = 1'b0;
    push_word(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, n);
    chk("bp first accept", n, 1);
    push_word(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, n);
    chk("bp second accept", n, 1);
    chk("bp tready low", s_ready, 0);
    m_ready = 1'b1;
    push_word(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, n);
    chk("bp third accept after pop", n, 5);
    repeat (12) @(posedge pl_clk);
    #1;
    chk("bp drained", m_valid, 0);

    // Random stalls, 12 counting words, frames of 4 words
    rst = 1'b0;
    @(posedge pl_clk); #1;
    rst = 1'b1;
    @(posedge pl_clk); #1;
    seen = 0;
    lasts = 0;
    cyc = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          int nn;
          push_word(cnt_word(4 * i), nn);
        end
      end
      begin
        while (seen < 48 && cyc < 3000) begin
          m_ready = 1'($urandom_range(0, 1));
          if (m_valid && m_ready) begin
            chk("stream data", m_data, seen);
            if (m_last) begin
              lasts++;
              chk("stream tlast position", seen + 1, lasts * 16);
            end
            seen++;
          end
          @(posedge pl_clk); #1;
          cyc++;
        end
      end
    join
    m_ready = 1'b1;
    chk("stream beat count", seen, 48);
    chk("stream tlast count", lasts, 3);
    chk("stream frames_done", frames, 3);

    // Flush mid-word
    push_word(cnt_word(500), n);
    repeat (5) @(posedge pl_clk);
    #1;
    m_ready = 1'b0;
    push_word(cnt_word(600), n);
    push_word(cnt_word(700), n);
    m_ready = 1'b1;
    @(posedge pl_clk); #1;
    @(posedge pl_clk); #1;
    chk("pre-flush beat2 data", m_data, 602);
    m_ready = 1'b0;
    flush = 1'b1;
    @(posedge pl_clk); #1;
    flush = 1'b0;
    chk("flush tvalid", m_valid, 0);
    chk("flush tready", s_ready, 0);
    chk("flush frames_done kept", frames, 3);
    @(posedge pl_clk); #1;
    chk("post-flush tready", s_ready, 1);
    m_ready = 1'b1;
    push_word(cnt_word(800), n);
    chk("post-flush beat0", m_data, 800);
    for (int i = 1; i < 4; i++) push_word(cnt_word(800 + 4 * i), n);
    repeat (20) @(posedge pl_clk);
    #1;
    chk("post-flush frame done", frames, 4);
    chk("post-flush drained", m_valid, 0);

    // Asynchronous reset mid-frame
    push_word(cnt_word(900), n);
    push_word(cnt_word(904), n);
    chk("pre-reset tvalid", m_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("async tvalid", m_valid, 0);
    chk("async tdata", m_data, 0);
    chk("async tlast", m_last, 0);
    chk("async tready", s_ready, 0);
    chk("async frames_done", frames, 0);
    @(posedge pl_clk); #1;
    rst = 1'b1;
    @(posedge pl_clk); #1;
    push_word(cnt_word(1000), n);
    chk("post-reset beat0", m_data, 1000);
    repeat (6) @(posedge pl_clk);
    #1;

    // 64-bit instance, one word per frame
    m_ready64 = 1'b1;
    s_valid64 = 1'b1;
    s_data64 = W0;
    acc64 = 1'b0;
    n64 = 0;
    while (!acc64 && n64 < 50) begin
      acc64 = s_ready64;
      @(posedge pl_clk); #1;
      n64++;
    end
    s_valid64 = 1'b0;
    chk("w64 accept", acc64, 1);
    chk("w64 beat0 valid", m_valid64, 1);
    chk("w64 beat0 data", m_data64, 64'h07060504_03020100);
    chk("w64 beat0 tlast", m_last64, 0);
    @(posedge pl_clk); #1;
    chk("w64 beat1 data", m_data64, 64'h0F0E0D0C_0B0A0908);
    chk("w64 beat1 tlast", m_last64, 1);
    @(posedge pl_clk); #1;
    chk("w64 drained", m_valid64, 0);
    chk("w64 frames_done", frames64, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
